// File: rtl/wb_regfile_pkg.sv
// Shared CPU package: datapath defaults and common register-file types.
package wb_regfile_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_NREGS  = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_CNT_W  = 32;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_WIDTH-1:0]  word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB -> writeback bus: MEM/WB register outputs in, ID/EX-facing results out.
interface wb_regfile_if
    import wb_regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
);

    logic              MEMTOREG_IN;
    logic              REGWRITE_IN;
    logic [WIDTH-1:0]  MEMDATA_IN;
    logic [WIDTH-1:0]  RESULTOP_IN;
    logic [ADDR_W-1:0] ARD_IN;
    logic [ADDR_W-1:0] ARS1_IN;
    logic [ADDR_W-1:0] ARS2_IN;
    logic [WIDTH-1:0]  RS1_DATA_OUT;
    logic [WIDTH-1:0]  RS2_DATA_OUT;
    logic [WIDTH-1:0]  WB_DATA_OUT;
    logic              WB_EN_OUT;
    logic [CNT_W-1:0]  WB_COUNT_OUT;

    modport master (
        output MEMTOREG_IN, REGWRITE_IN, MEMDATA_IN, RESULTOP_IN,
               ARD_IN, ARS1_IN, ARS2_IN,
        input  RS1_DATA_OUT, RS2_DATA_OUT, WB_DATA_OUT, WB_EN_OUT, WB_COUNT_OUT
    );

    modport slave (
        input  MEMTOREG_IN, REGWRITE_IN, MEMDATA_IN, RESULTOP_IN,
               ARD_IN, ARS1_IN, ARS2_IN,
        output RS1_DATA_OUT, RS2_DATA_OUT, WB_DATA_OUT, WB_EN_OUT, WB_COUNT_OUT
    );

endinterface

// File: rtl/wb_regfile_mux.sv
// Writeback select: load data or ALU result, shared by array write and bypass.
module wb_mux
    import wb_regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             memtoreg,
    input  logic [WIDTH-1:0] mem_data,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] wb_data
);

    // Select the value that retires this cycle.
    always_comb begin
        wb_data = memtoreg ? mem_data : alu_result;
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage register file: WB mux, GPR array with x0 hardwired,
// two write-first bypassed read ports and a retired-writeback counter.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NREGS  = DEF_NREGS,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    wb_regfile_if.slave   bus
);

    logic [WIDTH-1:0] wb_data;
    logic             wb_en;
    logic [WIDTH-1:0] regs [NREGS];
    logic [CNT_W-1:0] wb_count;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;

    wb_mux #(.WIDTH(WIDTH)) u_wb_mux (
        .memtoreg   (bus.MEMTOREG_IN),
        .mem_data   (bus.MEMDATA_IN),
        .alu_result (bus.RESULTOP_IN),
        .wb_data    (wb_data)
    );

    // A write commits only outside reset and never to x0 or an unmapped index.
    always_comb begin
        wb_en = bus.REGWRITE_IN && (bus.ARD_IN != ADDR_W'(REG_ZERO)) && rst
                && (int'(bus.ARD_IN) < NREGS);
    end

    // Register array: async clear, one write per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[bus.ARD_IN] <= wb_data;
        end
    end

    // Retired-writeback counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_count <= '0;
        end else if (wb_en) begin
            wb_count <= wb_count + 1'b1;
        end
    end

    // Read port 1: x0 -> 0, else write-first bypass, else array.
    always_comb begin
        rs1_data = '0;
        if (bus.ARS1_IN == ADDR_W'(REG_ZERO) || int'(bus.ARS1_IN) >= NREGS) begin
            rs1_data = '0;
        end else if (wb_en && bus.ARS1_IN == bus.ARD_IN) begin
            rs1_data = wb_data;
        end else begin
            rs1_data = regs[bus.ARS1_IN];
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rs2_data = '0;
        if (bus.ARS2_IN == ADDR_W'(REG_ZERO) || int'(bus.ARS2_IN) >= NREGS) begin
            rs2_data = '0;
        end else if (wb_en && bus.ARS2_IN == bus.ARD_IN) begin
            rs2_data = wb_data;
        end else begin
            rs2_data = regs[bus.ARS2_IN];
        end
    end

    // Drive the bus outputs.
    always_comb begin
        bus.RS1_DATA_OUT = rs1_data;
        bus.RS2_DATA_OUT = rs2_data;
        bus.WB_DATA_OUT  = wb_data;
        bus.WB_EN_OUT    = wb_en;
        bus.WB_COUNT_OUT = wb_count;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table plus reset,
// reset-mid-run and counter-wrap sequences.
module tb_wb_regfile;

    logic clk;
    logic rst;

    int checks;
    int failures;

    wb_regfile_if #(.WIDTH(32), .ADDR_W(5), .CNT_W(32)) bus_m ();
    wb_regfile_if #(.WIDTH(32), .ADDR_W(5), .CNT_W(4))  bus_w ();

    wb_regfile #(.WIDTH(32), .NREGS(32), .ADDR_W(5), .CNT_W(32)) dut_main (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    wb_regfile #(.WIDTH(32), .NREGS(32), .ADDR_W(5), .CNT_W(4)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mt;
        logic        rw;
        logic [31:0] md;
        logic [31:0] ro;
        logic [4:0]  ard;
        logic [4:0]  ars1;
        logic [4:0]  ars2;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_wb;
        logic        e_en;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(input logic mt, input logic rw,
                                input logic [31:0] md, input logic [31:0] ro,
                                input logic [4:0] ard, input logic [4:0] ars1,
                                input logic [4:0] ars2, input logic [31:0] e_rs1,
                                input logic [31:0] e_rs2, input logic [31:0] e_wb,
                                input logic e_en, input logic [31:0] e_cnt);
        vec_t v;
        v.mt = mt; v.rw = rw; v.md = md; v.ro = ro;
        v.ard = ard; v.ars1 = ars1; v.ars2 = ars2;
        v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_wb = e_wb;
        v.e_en = e_en; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_m();
        bus_m.MEMTOREG_IN = 1'b0;
        bus_m.REGWRITE_IN = 1'b0;
        bus_m.MEMDATA_IN  = '0;
        bus_m.RESULTOP_IN = '0;
        bus_m.ARD_IN      = '0;
        bus_m.ARS1_IN     = '0;
        bus_m.ARS2_IN     = '0;
    endtask

    task automatic idle_w();
        bus_w.MEMTOREG_IN = 1'b0;
        bus_w.REGWRITE_IN = 1'b0;
        bus_w.MEMDATA_IN  = '0;
        bus_w.RESULTOP_IN = '0;
        bus_w.ARD_IN      = '0;
        bus_w.ARS1_IN     = '0;
        bus_w.ARS2_IN     = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] last_w;
        checks   = 0;
        failures = 0;
        last_w   = '0;
        idle_m();
        idle_w();
        rst = 1'b1;

        // Vector table: state after a clean reset, applied in order.
        //            mt    rw    md            ro            ard    ars1   ars2   e_rs1         e_rs2         e_wb          en    cnt
        vecs[0] = mk(1'b0, 1'b1, 32'h0,        32'h12345678, 5'd21, 5'd21, 5'd0,  32'h12345678, 32'h0,        32'h12345678, 1'b1, 32'd1);
        vecs[1] = mk(1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  5'd21, 5'd21, 32'h12345678, 32'h12345678, 32'h0,        1'b0, 32'd1);
        vecs[2] = mk(1'b1, 1'b1, 32'hDEADBEEF, 32'h11111111, 5'd14, 5'd14, 5'd14, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 32'd2);
        vecs[3] = mk(1'b1, 1'b0, 32'h0,        32'h0,        5'd14, 5'd14, 5'd21, 32'hDEADBEEF, 32'h12345678, 32'h0,        1'b0, 32'd2);
        vecs[4] = mk(1'b0, 1'b1, 32'h0,        32'hFFFFFFFF, 5'd0,  5'd0,  5'd14, 32'h0,        32'hDEADBEEF, 32'hFFFFFFFF, 1'b0, 32'd2);
        vecs[5] = mk(1'b0, 1'b0, 32'h0,        32'h87654321, 5'd21, 5'd21, 5'd0,  32'h12345678, 32'h0,        32'h87654321, 1'b0, 32'd2);
        vecs[6] = mk(1'b1, 1'b0, 32'hCAFEF00D, 32'h0,        5'd21, 5'd21, 5'd14, 32'h12345678, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 32'd2);
        vecs[7] = mk(1'b0, 1'b1, 32'h0,        32'h00000007, 5'd5,  5'd14, 5'd5,  32'hDEADBEEF, 32'h00000007, 32'h00000007, 1'b1, 32'd3);
        vecs[8] = mk(1'b1, 1'b1, 32'h0BADF00D, 32'h0,        5'd21, 5'd5,  5'd21, 32'h00000007, 32'h0BADF00D, 32'h0BADF00D, 1'b1, 32'd4);
        vecs[9] = mk(1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  5'd21, 5'd5,  32'h0BADF00D, 32'h00000007, 32'h0,        1'b0, 32'd4);

        // T1: fill every register with garbage, then assert reset.
        for (int k = 1; k < 32; k++) begin
            @(negedge clk);
            bus_m.REGWRITE_IN = 1'b1;
            bus_m.ARD_IN      = 5'(k);
            bus_m.RESULTOP_IN = 32'hC0DE0000 | 32'(k);
            bus_w.REGWRITE_IN = 1'b1;
            bus_w.ARD_IN      = 5'd1;
            bus_w.RESULTOP_IN = 32'h5EED0000 | 32'(k);
        end
        @(negedge clk);
        bus_m.RESULTOP_IN = 32'h0F0F1234;
        bus_m.ARD_IN      = 5'd9;
        rst = 1'b0;
        #1;
        check("t1_wb_en", 32'(bus_m.WB_EN_OUT), 32'd0);
        check("t1_count", bus_m.WB_COUNT_OUT, 32'd0);
        check("t1_wrap_count", 32'(bus_w.WB_COUNT_OUT), 32'd0);
        check("t1_wb_data_mux", bus_m.WB_DATA_OUT, 32'h0F0F1234);
        for (int i = 1; i < 32; i++) begin
            bus_m.ARS1_IN = 5'(i);
            bus_m.ARS2_IN = 5'(32 - i);
            #1;
            check($sformatf("t1_rs1_r%0d", i), bus_m.RS1_DATA_OUT, 32'h0);
            check($sformatf("t1_rs2_r%0d", 32 - i), bus_m.RS2_DATA_OUT, 32'h0);
        end
        @(negedge clk);
        idle_m();
        idle_w();
        rst = 1'b1;

        // T2..T4 and extra patterns from the table.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus_m.MEMTOREG_IN = vecs[i].mt;
            bus_m.REGWRITE_IN = vecs[i].rw;
            bus_m.MEMDATA_IN  = vecs[i].md;
            bus_m.RESULTOP_IN = vecs[i].ro;
            bus_m.ARD_IN      = vecs[i].ard;
            bus_m.ARS1_IN     = vecs[i].ars1;
            bus_m.ARS2_IN     = vecs[i].ars2;
            #1;
            check($sformatf("v%0d_rs1", i), bus_m.RS1_DATA_OUT, vecs[i].e_rs1);
            check($sformatf("v%0d_rs2", i), bus_m.RS2_DATA_OUT, vecs[i].e_rs2);
            check($sformatf("v%0d_wb", i), bus_m.WB_DATA_OUT, vecs[i].e_wb);
            check($sformatf("v%0d_en", i), 32'(bus_m.WB_EN_OUT), 32'(vecs[i].e_en));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_cnt", i), bus_m.WB_COUNT_OUT, vecs[i].e_cnt);
        end

        // T5: reset between edges with a write pending.
        @(negedge clk);
        bus_m.MEMTOREG_IN = 1'b0;
        bus_m.REGWRITE_IN = 1'b1;
        bus_m.RESULTOP_IN = 32'hA5A5A5A5;
        bus_m.ARD_IN      = 5'd3;
        bus_m.ARS1_IN     = 5'd21;
        bus_m.ARS2_IN     = 5'd14;
        rst = 1'b0;
        #1;
        check("t5_rs1_r21", bus_m.RS1_DATA_OUT, 32'h0);
        check("t5_rs2_r14", bus_m.RS2_DATA_OUT, 32'h0);
        check("t5_count", bus_m.WB_COUNT_OUT, 32'd0);
        check("t5_wb_en", 32'(bus_m.WB_EN_OUT), 32'd0);
        check("t5_wb_data", bus_m.WB_DATA_OUT, 32'hA5A5A5A5);
        @(posedge clk);
        #1;
        check("t5_count_edge_in_reset", bus_m.WB_COUNT_OUT, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus_m.REGWRITE_IN = 1'b0;
        bus_m.ARS1_IN     = 5'd3;
        bus_m.ARS2_IN     = 5'd21;
        #1;
        check("t5_r3_not_committed", bus_m.RS1_DATA_OUT, 32'h0);
        check("t5_r21_cleared", bus_m.RS2_DATA_OUT, 32'h0);
        check("t5_count_release", bus_m.WB_COUNT_OUT, 32'd0);
        @(negedge clk);
        bus_m.REGWRITE_IN = 1'b1;
        @(posedge clk);
        #1;
        check("t5_count_after_write", bus_m.WB_COUNT_OUT, 32'd1);
        @(negedge clk);
        bus_m.REGWRITE_IN = 1'b0;
        bus_m.ARS1_IN     = 5'd3;
        bus_m.ARS2_IN     = 5'd14;
        #1;
        check("t5_r3_readback", bus_m.RS1_DATA_OUT, 32'hA5A5A5A5);
        check("t5_r14_cleared", bus_m.RS2_DATA_OUT, 32'h0);

        // T6: 4-bit counter wrap on the second instance.
        check("t6_wrap_start", 32'(bus_w.WB_COUNT_OUT), 32'd0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            bus_w.REGWRITE_IN = 1'b1;
            bus_w.ARD_IN      = 5'd1;
            bus_w.MEMTOREG_IN = k[0];
            bus_w.MEMDATA_IN  = 32'hB0000000 + 32'(k);
            bus_w.RESULTOP_IN = 32'h70000000 + 32'(k);
            last_w = k[0] ? 32'hB0000000 + 32'(k) : 32'h70000000 + 32'(k);
            @(posedge clk);
            #1;
            check($sformatf("t6_count_%0d", k), 32'(bus_w.WB_COUNT_OUT), 32'((k + 1) % 16));
        end
        @(negedge clk);
        bus_w.REGWRITE_IN = 1'b0;
        bus_w.ARS1_IN     = 5'd1;
        bus_w.ARS2_IN     = 5'd1;
        #1;
        check("t6_r1_last_p1", bus_w.RS1_DATA_OUT, last_w);
        check("t6_r1_last_p2", bus_w.RS2_DATA_OUT, last_w);
        check("t6_r1_expected", bus_w.RS1_DATA_OUT, 32'hB000000F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
